// File: rtl/oled_arb_pkg.sv
// Shared types and constants for the OLED pixel-source arbiter and its
// round-robin picker.
package oled_arb_pkg;

    localparam int SRC_IDX_W = 3;
    localparam int RGB_W     = 16;

    localparam logic [RGB_W-1:0] BLANK_DEFAULT = 16'h0000;

    typedef enum logic [1:0] {
        IDLE,
        SHOW,
        GAP
    } arb_state_e;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/oled_src_arbiter_rr_picker.sv
// Combinational round-robin picker: first requester after last_src (wrapping),
// with last_src itself considered last.
module rr_picker
    import oled_arb_pkg::*;
#(
    parameter int NSRC = 4
) (
    input  logic [NSRC-1:0]      i_req,
    input  logic [SRC_IDX_W-1:0] i_last_src,
    output logic [SRC_IDX_W-1:0] o_nxt,
    output logic                 o_any_other
);

    logic w_found;

    always_comb begin
        o_nxt   = '0;
        w_found = 1'b0;
        // Offset k walks last_src+1 .. last_src+NSRC, so last_src itself is checked last.
        for (int k = 1; k <= NSRC; k++) begin
            for (int i = 0; i < NSRC; i++) begin
                if (!w_found && i_req[i] && (i == ((int'(i_last_src) + k) % NSRC))) begin
                    o_nxt   = SRC_IDX_W'(i);
                    w_found = 1'b1;
                end
            end
        end
    end

    always_comb begin
        o_any_other = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            if (i_req[i] && (i != int'(i_last_src))) begin
                o_any_other = 1'b1;
            end
        end
    end

endmodule

// File: rtl/oled_src_arbiter.sv
// Frame-synchronous round-robin arbiter sharing the OLED pixel stream between
// several pixel generators, with a minimum dwell and optional blank gap frames.
module oled_src_arbiter
    import oled_arb_pkg::*;
#(
    parameter int               NSRC       = 4,
    parameter int               MIN_FRAMES = 8,
    parameter int               GAP_FRAMES = 1,
    parameter logic [RGB_W-1:0] BLANK      = BLANK_DEFAULT
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_frame_begin,
    input  logic [NSRC-1:0]         i_req,
    input  logic                    i_hold,
    input  logic [NSRC*RGB_W-1:0]   i_src_pixel,
    output logic [RGB_W-1:0]        o_pixel_data,
    output logic [NSRC-1:0]         o_grant,
    output logic [SRC_IDX_W-1:0]    o_active_src,
    output logic [7:0]              o_dwell
);

    arb_state_e             r_state,   w_state_nxt;
    logic [NSRC-1:0]        r_grant,   w_grant_nxt;
    logic [SRC_IDX_W-1:0]   r_active,  w_active_nxt;
    logic [SRC_IDX_W-1:0]   r_last,    w_last_nxt;
    logic [SRC_IDX_W-1:0]   r_pend,    w_pend_nxt;
    logic [7:0]             r_dwell,   w_dwell_nxt;
    logic [1:0]             r_gap_cnt, w_gap_cnt_nxt;

    logic [SRC_IDX_W-1:0]   w_pick;
    logic                   w_any_other;
    logic                   w_load;
    logic [SRC_IDX_W-1:0]   w_load_src;
    logic                   w_switch;
    logic                   w_to_idle;

    function automatic logic [NSRC-1:0] onehot(input logic [SRC_IDX_W-1:0] s);
        logic [NSRC-1:0] v;
        v = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (i == int'(s)) v[i] = 1'b1;
        end
        return v;
    endfunction

    function automatic logic req_at(input logic [NSRC-1:0] r, input logic [SRC_IDX_W-1:0] s);
        logic b;
        b = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            if (i == int'(s)) b = r[i];
        end
        return b;
    endfunction

    // In SHOW last_src equals the active source, so any_other means "someone else wants it".
    rr_picker #(
        .NSRC (NSRC)
    ) u_picker (
        .i_req       (i_req),
        .i_last_src  (r_last),
        .o_nxt       (w_pick),
        .o_any_other (w_any_other)
    );

    always_comb begin
        w_state_nxt   = r_state;
        w_grant_nxt   = r_grant;
        w_active_nxt  = r_active;
        w_last_nxt    = r_last;
        w_pend_nxt    = r_pend;
        w_dwell_nxt   = r_dwell;
        w_gap_cnt_nxt = r_gap_cnt;
        w_load        = 1'b0;
        w_load_src    = w_pick;
        w_switch      = 1'b0;
        w_to_idle     = 1'b0;

        if (i_frame_begin) begin
            unique case (r_state)
                IDLE: begin
                    if (|i_req) w_load = 1'b1;
                end
                SHOW: begin
                    w_dwell_nxt = sat_inc8(r_dwell);
                    if (!i_hold) begin
                        if (!req_at(i_req, r_active)) begin
                            if (w_any_other) w_switch  = 1'b1;
                            else             w_to_idle = 1'b1;
                        end else if ((w_dwell_nxt >= 8'(MIN_FRAMES)) && w_any_other) begin
                            w_switch = 1'b1;
                        end
                    end
                end
                GAP: begin
                    if (r_gap_cnt != 2'd0) begin
                        w_gap_cnt_nxt = r_gap_cnt - 2'd1;
                    end else if (req_at(i_req, r_pend)) begin
                        w_load     = 1'b1;
                        w_load_src = r_pend;
                    end else if (|i_req) begin
                        w_load = 1'b1;
                    end else begin
                        w_to_idle = 1'b1;
                    end
                end
                default: w_to_idle = 1'b1;
            endcase

            if (w_switch) begin
                if (GAP_FRAMES == 0) begin
                    w_load = 1'b1;
                end else begin
                    w_state_nxt   = GAP;
                    w_grant_nxt   = '0;
                    w_active_nxt  = '0;
                    w_dwell_nxt   = '0;
                    w_gap_cnt_nxt = 2'(GAP_FRAMES - 1);
                    w_pend_nxt    = w_pick;
                end
            end

            if (w_to_idle) begin
                w_state_nxt  = IDLE;
                w_grant_nxt  = '0;
                w_active_nxt = '0;
                w_dwell_nxt  = '0;
            end

            if (w_load) begin
                w_state_nxt  = SHOW;
                w_grant_nxt  = onehot(w_load_src);
                w_active_nxt = w_load_src;
                w_last_nxt   = w_load_src;
                w_dwell_nxt  = '0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= IDLE;
            r_grant   <= '0;
            r_active  <= '0;
            r_last    <= SRC_IDX_W'(NSRC - 1);
            r_pend    <= '0;
            r_dwell   <= '0;
            r_gap_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_grant   <= w_grant_nxt;
            r_active  <= w_active_nxt;
            r_last    <= w_last_nxt;
            r_pend    <= w_pend_nxt;
            r_dwell   <= w_dwell_nxt;
            r_gap_cnt <= w_gap_cnt_nxt;
        end
    end

    // Pixel mux stays combinational so the source's pixel_index->pixel path gains no latency.
    always_comb begin
        o_pixel_data = BLANK;
        for (int i = 0; i < NSRC; i++) begin
            if ((r_grant != '0) && (i == int'(r_active))) begin
                o_pixel_data = i_src_pixel[i*RGB_W +: RGB_W];
            end
        end
    end

    assign o_grant      = r_grant;
    assign o_active_src = r_active;
    assign o_dwell      = r_dwell;

endmodule

// File: tb/tb_oled_src_arbiter.sv
// Self-checking bench for oled_src_arbiter: directed scenarios plus randomized
// frames checked against a frame-level behavioural model.
module tb_oled_src_arbiter;

    localparam int NSRC  = 4;
    localparam int MIN_F = 8;
    localparam int GAP_F = 1;

    logic        clk = 1'b0;
    logic        i_reset = 1'b0;
    logic        i_frame_begin = 1'b0;
    logic [3:0]  i_req = 4'd0;
    logic        i_hold = 1'b0;
    logic [15:0] pix [4];
    logic [63:0] i_src_pixel;
    logic [15:0] o_pixel_data;
    logic [3:0]  o_grant;
    logic [2:0]  o_active_src;
    logic [7:0]  o_dwell;

    int total = 0;
    int bad   = 0;

    // Model state: m_src = granted source or -1; m_gap marks a blank gap.
    int m_src, m_last, m_dwell, m_gap, m_gcnt, m_pend;

    assign i_src_pixel = {pix[3], pix[2], pix[1], pix[0]};

    always #5 clk = ~clk;

    oled_src_arbiter #(
        .NSRC       (NSRC),
        .MIN_FRAMES (MIN_F),
        .GAP_FRAMES (GAP_F),
        .BLANK      (16'h0000)
    ) dut (
        .i_clk         (clk),
        .i_reset       (i_reset),
        .i_frame_begin (i_frame_begin),
        .i_req         (i_req),
        .i_hold        (i_hold),
        .i_src_pixel   (i_src_pixel),
        .o_pixel_data  (o_pixel_data),
        .o_grant       (o_grant),
        .o_active_src  (o_active_src),
        .o_dwell       (o_dwell)
    );

    function automatic bit has(input logic [3:0] rq, input int i);
        return ((rq >> i) & 4'd1) != 4'd0;
    endfunction

    function automatic int pick(input logic [3:0] rq, input int from);
        for (int k = 1; k <= NSRC; k++) begin
            if (has(rq, (from + k) % NSRC)) return (from + k) % NSRC;
        end
        return -1;
    endfunction

    function automatic logic [3:0] e_grant();
        return (m_src < 0) ? 4'd0 : 4'(1 << m_src);
    endfunction

    function automatic logic [2:0] e_active();
        return (m_src < 0) ? 3'd0 : 3'(m_src);
    endfunction

    function automatic logic [15:0] e_pixel();
        return (m_src < 0) ? 16'h0000 : pix[m_src[1:0]];
    endfunction

    task automatic m_load(input int s);
        m_src = s; m_last = s; m_dwell = 0; m_gap = 0;
    endtask

    task automatic m_idle();
        m_src = -1; m_gap = 0; m_dwell = 0;
    endtask

    task automatic model_reset();
        m_src = -1; m_last = NSRC - 1; m_dwell = 0; m_gap = 0; m_gcnt = 0; m_pend = 0;
    endtask

    task automatic model_frame(input logic [3:0] rq, input logic h);
        int s;
        logic [3:0] others;
        if (m_gap != 0) begin
            if (m_gcnt > 0) m_gcnt--;
            else begin
                s = has(rq, m_pend) ? m_pend : pick(rq, m_last);
                if (s < 0) m_idle(); else m_load(s);
            end
        end else if (m_src < 0) begin
            s = pick(rq, m_last);
            if (s >= 0) m_load(s);
        end else begin
            m_dwell = (m_dwell < 255) ? m_dwell + 1 : 255;
            others  = rq & ~(4'b0001 << m_src);
            if (!h && (!has(rq, m_src) || m_dwell >= MIN_F)) begin
                if (others != 4'd0) begin
                    s = pick(rq, m_last);
                    if (GAP_F == 0) m_load(s);
                    else begin
                        m_src = -1; m_gap = 1; m_gcnt = GAP_F - 1; m_pend = s; m_dwell = 0;
                    end
                end else if (!has(rq, m_src)) begin
                    m_idle();
                end
            end
        end
    endtask

    // Drive one cycle's inputs, advance the model, return #1 after the edge.
    task automatic drive(input logic fb, input logic [3:0] rq, input logic h, input logic rst);
        i_frame_begin = fb; i_req = rq; i_hold = h; i_reset = rst;
        if (rst) model_reset();
        else if (fb) model_frame(rq, h);
        @(posedge clk); #1;
    endtask

    task automatic frame(input logic [3:0] rq, input logic h, input int len);
        drive(1'b1, rq, h, 1'b0);
        for (int c = 1; c < len; c++) drive(1'b0, rq, h, 1'b0);
    endtask

    task automatic do_reset();
        drive(1'b0, 4'd0, 1'b0, 1'b1);
        drive(1'b0, 4'd0, 1'b0, 1'b1);
        drive(1'b0, 4'd0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        for (int c = 0; c < 3; c++) begin
            drive(c == 1, 4'd0, 1'b0, 1'b1);
            total++;
            if (o_grant !== 4'd0 || o_active_src !== 3'd0 || o_dwell !== 8'd0 || o_pixel_data !== 16'h0000) begin
                bad++;
                $display("FAIL reset_cyc c=%0d grant=%b act=%0d dwell=%0d pix=%h want all zero", c, o_grant, o_active_src, o_dwell, o_pixel_data);
            end
        end
        for (int f = 0; f < 5; f++) begin
            frame(4'd0, 1'b0, 3);
            total++;
            if (o_grant !== 4'd0 || o_active_src !== 3'd0 || o_dwell !== 8'd0 || o_pixel_data !== 16'h0000) begin
                bad++;
                $display("FAIL reset_idle f=%0d grant=%b act=%0d dwell=%0d pix=%h want all zero", f, o_grant, o_active_src, o_dwell, o_pixel_data);
            end
        end
    endtask

    task automatic test_single_grant();
        do_reset();
        pix[0] = 16'h1234; pix[1] = 16'hF800; pix[2] = 16'h07E0; pix[3] = 16'h001F;
        drive(1'b1, 4'd0, 1'b0, 1'b0);
        drive(1'b0, 4'd0, 1'b0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            drive(1'b0, 4'b0010, 1'b0, 1'b0);
            total++;
            if (o_pixel_data !== 16'h0000 || o_grant !== 4'd0) begin
                bad++;
                $display("FAIL single_midframe c=%0d pix=%h grant=%b want 0000/0000", c, o_pixel_data, o_grant);
            end
        end
        for (int c = 0; c < 4; c++) begin
            drive(c == 0, 4'b0010, 1'b0, 1'b0);
            total++;
            if (o_grant !== 4'b0010 || o_active_src !== 3'd1 || o_pixel_data !== 16'hF800) begin
                bad++;
                $display("FAIL single_grant c=%0d grant=%b act=%0d pix=%h want 0010/1/f800", c, o_grant, o_active_src, o_pixel_data);
            end
        end
    endtask

    task automatic test_rotation();
        logic [3:0] g_exp;
        int d_exp;
        do_reset();
        for (int i = 0; i < 4; i++) pix[i] = 16'($urandom_range(16'hFFFF, 1));
        for (int f = 0; f < 20; f++) begin
            frame(4'b0011, 1'b0, 4);
            if (f < 8)       begin g_exp = 4'b0001; d_exp = f;      end
            else if (f == 8) begin g_exp = 4'b0000; d_exp = 0;      end
            else if (f < 17) begin g_exp = 4'b0010; d_exp = f - 9; end
            else if (f == 17) begin g_exp = 4'b0000; d_exp = 0;     end
            else             begin g_exp = 4'b0001; d_exp = f - 18; end
            total++;
            if (o_grant !== g_exp || o_pixel_data !== e_pixel() ||
                (g_exp != 4'd0 && o_dwell !== 8'(d_exp))) begin
                bad++;
                $display("FAIL rotation f=%0d grant=%b want %b pix=%h want %h dwell=%0d want %0d",
                         f, o_grant, g_exp, o_pixel_data, e_pixel(), o_dwell, d_exp);
            end
        end
    endtask

    task automatic test_hold();
        do_reset();
        frame(4'b0100, 1'b0, 3);
        total++;
        if (o_grant !== 4'b0100) begin
            bad++; $display("FAIL hold_setup grant=%b want 0100", o_grant);
        end
        for (int f = 1; f <= 20; f++) begin
            frame(4'b1111, 1'b1, 3);
            total++;
            if (o_grant !== 4'b0100 || o_dwell !== 8'(f)) begin
                bad++; $display("FAIL hold f=%0d grant=%b dwell=%0d want 0100/%0d", f, o_grant, o_dwell, f);
            end
        end
        frame(4'b1111, 1'b0, 3);
        total++;
        if (o_grant !== 4'b0000 || o_pixel_data !== 16'h0000) begin
            bad++; $display("FAIL hold_release grant=%b pix=%h want 0000/0000", o_grant, o_pixel_data);
        end
        frame(4'b1111, 1'b0, 3);
        total++;
        if (o_grant !== 4'b1000 || o_active_src !== 3'd3) begin
            bad++; $display("FAIL hold_next grant=%b act=%0d want 1000/3", o_grant, o_active_src);
        end
    endtask

    task automatic test_req_drop();
        do_reset();
        frame(4'b1000, 1'b0, 3);
        frame(4'b1001, 1'b0, 3);
        drive(1'b1, 4'b1001, 1'b0, 1'b0);
        drive(1'b0, 4'b1001, 1'b0, 1'b0);
        total++;
        if (o_grant !== 4'b1000 || o_dwell !== 8'd2) begin
            bad++; $display("FAIL drop_setup grant=%b dwell=%0d want 1000/2", o_grant, o_dwell);
        end
        drive(1'b0, 4'b0001, 1'b0, 1'b0);
        total++;
        if (o_grant !== 4'b1000 || o_pixel_data !== pix[3]) begin
            bad++; $display("FAIL drop_midframe grant=%b pix=%h want 1000/%h", o_grant, o_pixel_data, pix[3]);
        end
        frame(4'b0001, 1'b0, 3);
        total++;
        if (o_grant !== 4'b0000 || o_pixel_data !== 16'h0000) begin
            bad++; $display("FAIL drop_gap grant=%b pix=%h want 0000/0000", o_grant, o_pixel_data);
        end
        frame(4'b0001, 1'b0, 3);
        total++;
        if (o_grant !== 4'b0001 || o_active_src !== 3'd0 || o_pixel_data !== pix[0]) begin
            bad++; $display("FAIL drop_next grant=%b act=%0d want 0001/0", o_grant, o_active_src);
        end
        // Variant: every request drops, so the screen goes blank and idle.
        do_reset();
        frame(4'b1000, 1'b0, 3);
        frame(4'b1000, 1'b0, 3);
        drive(1'b1, 4'b1000, 1'b0, 1'b0);
        drive(1'b0, 4'b0000, 1'b0, 1'b0);
        for (int f = 0; f < 2; f++) begin
            frame(4'b0000, 1'b0, 3);
            total++;
            if (o_grant !== 4'b0000 || o_active_src !== 3'd0 || o_pixel_data !== 16'h0000) begin
                bad++; $display("FAIL drop_idle f=%0d grant=%b act=%0d pix=%h want blank", f, o_grant, o_active_src, o_pixel_data);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        frame(4'b0001, 1'b0, 3);
        frame(4'b0011, 1'b0, 3);
        drive(1'b1, 4'b0010, 1'b0, 1'b0);
        total++;
        if (o_grant !== 4'b0000) begin
            bad++; $display("FAIL rstmid_gap grant=%b want 0000", o_grant);
        end
        drive(1'b1, 4'b0101, 1'b0, 1'b1);
        total++;
        if (o_grant !== 4'b0000 || o_active_src !== 3'd0 || o_dwell !== 8'd0) begin
            bad++; $display("FAIL rstmid_reset grant=%b act=%0d dwell=%0d want 0", o_grant, o_active_src, o_dwell);
        end
        drive(1'b0, 4'b0101, 1'b0, 1'b0);
        frame(4'b0101, 1'b0, 3);
        total++;
        if (o_grant !== 4'b0001 || o_active_src !== 3'd0) begin
            bad++; $display("FAIL rstmid_regrant grant=%b act=%0d want 0001/0", o_grant, o_active_src);
        end
        frame(4'b0100, 1'b0, 3);
        frame(4'b0100, 1'b0, 3);
        do_reset();
        frame(4'b0100, 1'b0, 3);
        total++;
        if (o_grant !== 4'b0100 || o_active_src !== 3'd2) begin
            bad++; $display("FAIL rstmid_src2 grant=%b act=%0d want 0100/2", o_grant, o_active_src);
        end
    endtask

    task automatic test_random();
        logic [3:0] rq;
        logic h, rst;
        int len;
        do_reset();
        for (int f = 0; f < 400; f++) begin
            len = $urandom_range(5, 2);
            rq  = ($urandom_range(3, 0) == 0) ? 4'd0 : 4'($urandom);
            h   = ($urandom_range(7, 0) == 0);
            rst = ($urandom_range(49, 0) == 0);
            for (int i = 0; i < 4; i++) pix[i] = 16'($urandom);
            for (int c = 0; c < len; c++) begin
                if (c > 0 && $urandom_range(3, 0) == 0) rq = 4'($urandom);
                drive(c == 0, rq, h, (c == 0) && rst);
                total++;
                if (o_grant !== e_grant() || o_active_src !== e_active() || o_pixel_data !== e_pixel() ||
                    (m_src >= 0 && o_dwell !== 8'(m_dwell))) begin
                    bad++;
                    $display("FAIL random f=%0d c=%0d grant=%b/%b act=%0d/%0d pix=%h/%h dwell=%0d/%0d (got/want)",
                             f, c, o_grant, e_grant(), o_active_src, e_active(), o_pixel_data, e_pixel(), o_dwell, m_dwell);
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) pix[i] = 16'h0000;
        model_reset();
        test_reset();
        test_single_grant();
        test_rotation();
        test_hold();
        test_req_drop();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
